// File: rtl/time_display.sv
// Six-digit HH:MM:SS multiplexed 7-segment driver with a double-dabble BCD converter.
// Optional macro LEADING_ZERO_BLANK_EN blanks a zero hour-tens digit.
module time_display #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [4:0] hour,
  input  logic [5:0] min,
  input  logic [5:0] sec,
  input  logic       load,
  output logic       busy,
  output logic [6:0] seg,
  output logic       dp,
  output logic [5:0] dig_sel
);

  localparam int unsigned PW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IN_W    = 6;
  localparam int unsigned BCD_W   = 8;
  localparam int unsigned STEP_W  = IN_W + BCD_W;
  localparam int unsigned N_ITER  = 6;

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_e;

  state_e state_q, state_d;
  logic   capture_c, shift_c, commit_c;
  logic   busy_q;

  logic [2:0][IN_W-1:0]   sh_q;
  logic [2:0][BCD_W-1:0]  bcd_q;
  logic [2:0][STEP_W-1:0] step_c;
  logic [2:0]             cnt_q;
  logic [5:0][3:0]        dig_q;
  logic [PW-1:0]          presc_q;
  logic [2:0]             idx_q;
  logic [3:0]             cur_c;

  // One double-dabble iteration: add 3 to any nibble >= 5, then shift left.
  function automatic logic [STEP_W-1:0] dd_step(input logic [STEP_W-1:0] v);
    logic [3:0] lo, hi;
    lo = v[9:6];
    hi = v[13:10];
    if (lo >= 4'd5) lo = lo + 4'd3;
    if (hi >= 4'd5) hi = hi + 4'd3;
    return {hi[2:0], lo, v[5:0], 1'b0};
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load) state_d = CONV;
      CONV:    if (cnt_q == 3'(N_ITER - 1)) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    capture_c = 1'b0;
    shift_c   = 1'b0;
    commit_c  = 1'b0;
    case (state_q)
      IDLE:    capture_c = load;
      CONV:    shift_c   = 1'b1;
      COMMIT:  commit_c  = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    for (int i = 0; i < 3; i++) step_c[i] = dd_step({bcd_q[i], sh_q[i]});
  end

  // Field order in sh_q/bcd_q: [2]=hour, [1]=minute, [0]=second.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh_q  <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      dig_q <= '0;
    end else if (capture_c) begin
      sh_q  <= {{1'b0, hour}, min, sec};
      bcd_q <= '0;
      cnt_q <= '0;
    end else if (shift_c) begin
      for (int i = 0; i < 3; i++) begin
        sh_q[i]  <= step_c[i][IN_W-1:0];
        bcd_q[i] <= step_c[i][STEP_W-1:IN_W];
      end
      cnt_q <= cnt_q + 3'd1;
    end else if (commit_c) begin
      dig_q <= {bcd_q[2], bcd_q[1], bcd_q[0]};
    end
  end

  // Free-running scan, independent of conversions.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
      idx_q   <= '0;
    end else if (presc_q == PW'(SCAN_DIV - 1)) begin
      presc_q <= '0;
      idx_q   <= (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
    end else begin
      presc_q <= presc_q + PW'(1);
    end
  end

  always_comb begin
    cur_c = dig_q[0];
    case (idx_q)
      3'd1:    cur_c = dig_q[1];
      3'd2:    cur_c = dig_q[2];
      3'd3:    cur_c = dig_q[3];
      3'd4:    cur_c = dig_q[4];
      3'd5:    cur_c = dig_q[5];
      default: cur_c = dig_q[0];
    endcase
    seg = seg7(cur_c);
`ifdef LEADING_ZERO_BLANK_EN
    if (idx_q == 3'd5 && cur_c == 4'd0) seg = 7'h00;
`else
`endif
  end

  assign busy    = busy_q;
  assign dig_sel = 6'b000001 << idx_q;
  assign dp      = (idx_q == 3'd4) || (idx_q == 3'd2);

endmodule

// File: tb/tb_time_display.sv
// Self-checking bench for time_display: arithmetic reference model plus directed literal checks.
module tb_time_display;

  localparam int unsigned D = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       load = 1'b0;
  logic [4:0] hour = '0;
  logic [5:0] min = '0;
  logic [5:0] sec = '0;
  logic       busy, dp, f_busy, f_dp;
  logic [6:0] seg, f_seg;
  logic [5:0] dig_sel, f_dig_sel;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  localparam logic [6:0] SEG_TAB [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                          7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  time_display #(.SCAN_DIV(D)) dut (
    .clk(clk), .reset_n(reset_n), .hour(hour), .min(min), .sec(sec), .load(load),
    .busy(busy), .seg(seg), .dp(dp), .dig_sel(dig_sel)
  );

  time_display #(.SCAN_DIV(1)) dut_fast (
    .clk(clk), .reset_n(reset_n), .hour(hour), .min(min), .sec(sec), .load(load),
    .busy(f_busy), .seg(f_seg), .dp(f_dp), .dig_sel(f_dig_sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Display digits packed 4 bits each, position p (0=sec units .. 5=hour tens) at [4p+:4].
  function automatic logic [23:0] to_digits(input int h, input int m, input int s);
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  // Reference model: edge count since reset, pending commit time and shown digits.
  int          m_cyc = 0;
  int          m_at = 0;
  logic        m_pend = 1'b0;
  logic [23:0] m_val = '0;
  logic [23:0] m_dig = '0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_cyc  <= 0;
      m_pend <= 1'b0;
      m_dig  <= '0;
    end else begin
      m_cyc <= m_cyc + 1;
      if (load && !m_pend) begin
        m_pend <= 1'b1;
        m_at   <= m_cyc + 1 + 7;
        m_val  <= to_digits(int'(hour), int'(min), int'(sec));
      end else if (m_pend && (m_cyc + 1 == m_at)) begin
        m_pend <= 1'b0;
        m_dig  <= m_val;
      end
    end
  end

  always @(negedge clk) begin : cmp
    int         idx;
    logic [3:0] d;
    logic [6:0] es;
    if (chk_en) begin
      idx = (m_cyc / D) % 6;
      d   = m_dig[4*idx +: 4];
      es  = (d < 10) ? SEG_TAB[d] : 7'h00;
      if (BLANK && idx == 5 && d == 4'd0) es = 7'h00;
      chk("busy", busy, m_pend);
      chk("dig_sel", dig_sel, 1 << idx);
      chk("dp", dp, (idx == 4 || idx == 2) ? 1 : 0);
      chk("seg", seg, es);
      chk("fast_dig_sel", f_dig_sel, 1 << (m_cyc % 6));
      chk("fast_busy", f_busy, m_pend);
    end
  end

  task automatic do_load(input int h, input int m, input int s);
    @(negedge clk);
    hour = 5'(h); min = 6'(m); sec = 6'(s); load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", busy, 0);
  endtask

  task automatic expect_pos(input int p, input int exp_seg);
    int n = 0;
    while (dig_sel != 6'(1 << p) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("pos%0d_found", p), dig_sel, 1 << p);
    chk($sformatf("pos%0d_seg", p), seg, exp_seg);
    chk($sformatf("pos%0d_dp", p), dp, (p == 4 || p == 2) ? 1 : 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    // Scenario 1: reset
    repeat (3) @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_seg", seg, 7'h3F);
    chk("rst_dig_sel", dig_sel, 6'b000001);
    chk("rst_busy", busy, 0);
    chk("rst_dp", dp, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Scenario 2: 23:59:58, busy length and scan literals
    do_load(23, 59, 58);
    n = 0;
    while (busy && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("busy_len", n, 7);
    chk("model_h_tens", m_dig[23:20], 2);
    chk("model_s_units", m_dig[3:0], 8);
    expect_pos(5, 7'h5B);
    expect_pos(4, 7'h4F);
    expect_pos(3, 7'h6D);
    expect_pos(2, 7'h6F);
    expect_pos(1, 7'h6D);
    expect_pos(0, 7'h7F);

    // Scenario 4: scan period and wrap 100000 -> 000001
    expect_pos(5, 7'h5B);
    n = 0;
    while (dig_sel == 6'b100000 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("wrap_to_0", dig_sel, 6'b000001);
    n = 0;
    while (dig_sel == 6'b000001 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("scan_period", n, D);

    // Scenario 3: back-to-back load, second ignored
    @(negedge clk);
    hour = 5'd10; min = 6'd20; sec = 6'd30; load = 1'b1;
    @(negedge clk);
    hour = 5'd11; min = 6'd22; sec = 6'd33;
    @(negedge clk);
    load = 1'b0;
    wait_idle();
    expect_pos(5, 7'h06);
    expect_pos(3, 7'h5B);
    expect_pos(1, 7'h4F);

    // Out-of-range values are not clamped
    do_load(31, 63, 0);
    wait_idle();
    expect_pos(5, 7'h4F);
    expect_pos(4, 7'h06);
    expect_pos(3, 7'h7D);
    expect_pos(2, 7'h4F);

    // Scenario 5: leading hour-tens zero
    do_load(7, 0, 0);
    wait_idle();
    expect_pos(5, BLANK ? 7'h00 : 7'h3F);
    expect_pos(4, 7'h07);

    // Scenario 6: reset during CONV aborts conversion
    @(posedge clk); #2 reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    do_load(12, 34, 56);
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b0;
    @(negedge clk);
    chk("abort_busy_rst", busy, 0);
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_model", m_dig, 0);
    expect_pos(2, 7'h3F);
    expect_pos(0, 7'h3F);
    do_load(12, 34, 56);
    wait_idle();
    expect_pos(5, 7'h06);
    expect_pos(3, 7'h4F);
    expect_pos(0, 7'h7D);

    repeat (4) @(negedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
